fpu_uart_cmd_rx: RTL and testbench

//  UART receiver and command-frame assembler upstream of the half-precision FPU FSM.

---
 rtl/fpu_uart_cmd_rx_if.sv | 25 ++
 rtl/fpu_uart_cmd_rx.sv | 211 +++++++++++++++++++++
 tb/tb_fpu_uart_cmd_rx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_uart_cmd_rx_if.sv
// Command-word handshake between the UART command receiver and the FPU FSM.
// The receiver drives the command; the consumer drives cmd_ready.
interface fpu_uart_cmd_rx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_op_a;
  logic [15:0] cmd_op_b;

  modport master (
    output cmd_valid,
    output cmd_opcode,
    output cmd_op_a,
    output cmd_op_b,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_opcode,
    input  cmd_op_a,
    input  cmd_op_b,
    output cmd_ready
  );
endinterface

// File: rtl/fpu_uart_cmd_rx.sv
// 8N1 UART receiver that assembles five-byte FPU command packets (opcode, A, B)
// and presents them on a valid/ready port, with framing/overrun pulses and an idle timeout.
module fpu_uart_cmd_rx #(
  parameter int TIMEOUT_BITS = 32,
  parameter int MIN_CPB      = 4
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      r_Rx_Serial,
  input  logic [15:0]               CLKS_PER_BIT,
  fpu_uart_cmd_rx_if.master         cmd,
  output logic                      frame_err,
  output logic                      overrun_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rxState_e;

  logic        rxMeta_q;
  logic        rxSync_q;

  rxState_e    state_q;
  logic [15:0] bitCnt_q;
  logic [2:0]  bitIdx_q;
  logic [7:0]  shift_q;
  logic [15:0] cpbShadow_q;
  logic        byteOk_q;
  logic        frameErr_q;

  logic [2:0]       byteIdx_q,  byteIdx_d;
  logic [3:0][7:0]  byteBuf_q,  byteBuf_d;
  logic [21:0]      idleCnt_q,  idleCnt_d;
  logic             cmdValid_q, cmdValid_d;
  logic [7:0]       opcode_q,   opcode_d;
  logic [15:0]      opA_q,      opA_d;
  logic [15:0]      opB_q,      opB_d;
  logic             overrunErr_q, overrunErr_d;

  logic [15:0] cpbEff;
  logic [15:0] halfLast;
  logic [15:0] fullLast;
  logic [37:0] timeoutProd;
  logic [21:0] timeoutLimit;
  logic        startDetect;
  logic        idleRun;
  logic        timeoutHit;
  logic        accept;

  // Two-flop synchroniser; the line idles high so reset to 1 avoids a false start.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= r_Rx_Serial;
      rxSync_q <= rxMeta_q;
    end
  end

  assign cpbEff   = (cpbShadow_q < 16'(MIN_CPB)) ? 16'(MIN_CPB) : cpbShadow_q;
  assign halfLast = (cpbEff >> 1) - 16'd1;
  assign fullLast = cpbEff - 16'd1;

  assign startDetect = (state_q == IDLE) && !rxSync_q;

  // Bit-level FSM. Leaving STOP at mid-bit lets the next start edge be caught promptly.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      cpbShadow_q <= '0;
      byteOk_q    <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      byteOk_q   <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_q     <= START;
            bitCnt_q    <= '0;
            cpbShadow_q <= CLKS_PER_BIT;
          end
        end
        START: begin
          if (bitCnt_q == halfLast) begin
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            state_q  <= rxSync_q ? IDLE : DATA;
          end else begin
            bitCnt_q <= bitCnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bitCnt_q == fullLast) begin
            bitCnt_q <= '0;
            shift_q  <= {rxSync_q, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            bitCnt_q <= bitCnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bitCnt_q == fullLast) begin
            bitCnt_q <= '0;
            state_q  <= IDLE;
            if (rxSync_q) begin
              byteOk_q <= 1'b1;
            end else begin
              frameErr_q <= 1'b1;
            end
          end else begin
            bitCnt_q <= bitCnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The product can exceed the 22-bit idle counter for large parameters, so it saturates.
  assign timeoutProd  = 38'(TIMEOUT_BITS) * {22'd0, cpbEff};
  assign timeoutLimit = (|timeoutProd[37:22]) ? '1 : timeoutProd[21:0];
  assign idleRun      = (byteIdx_q != 3'd0) && (state_q == IDLE);
  assign timeoutHit   = idleRun && (idleCnt_q >= timeoutLimit);
  assign accept       = cmdValid_q && cmd.cmd_ready;

  // Packet assembly and output handshake; an accept in the completion cycle frees the slot.
  always_comb begin
    byteIdx_d    = byteIdx_q;
    byteBuf_d    = byteBuf_q;
    idleCnt_d    = idleCnt_q;
    cmdValid_d   = cmdValid_q;
    opcode_d     = opcode_q;
    opA_d        = opA_q;
    opB_d        = opB_q;
    overrunErr_d = 1'b0;

    if (accept) begin
      cmdValid_d = 1'b0;
    end

    if (startDetect) begin
      idleCnt_d = '0;
    end else if (idleRun && (idleCnt_q != '1)) begin
      idleCnt_d = idleCnt_q + 22'd1;
    end

    if (frameErr_q) begin
      byteIdx_d = '0;
    end else if (byteOk_q) begin
      if (byteIdx_q == 3'd4) begin
        byteIdx_d = '0;
        if (!cmdValid_q || accept) begin
          cmdValid_d = 1'b1;
          opcode_d   = byteBuf_q[0];
          opA_d      = {byteBuf_q[1], byteBuf_q[2]};
          opB_d      = {byteBuf_q[3], shift_q};
        end else begin
          overrunErr_d = 1'b1;
        end
      end else begin
        byteBuf_d[byteIdx_q[1:0]] = shift_q;
        byteIdx_d                 = byteIdx_q + 3'd1;
      end
    end else if (timeoutHit) begin
      byteIdx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      byteIdx_q    <= '0;
      byteBuf_q    <= '0;
      idleCnt_q    <= '0;
      cmdValid_q   <= 1'b0;
      opcode_q     <= '0;
      opA_q        <= '0;
      opB_q        <= '0;
      overrunErr_q <= 1'b0;
    end else begin
      byteIdx_q    <= byteIdx_d;
      byteBuf_q    <= byteBuf_d;
      idleCnt_q    <= idleCnt_d;
      cmdValid_q   <= cmdValid_d;
      opcode_q     <= opcode_d;
      opA_q        <= opA_d;
      opB_q        <= opB_d;
      overrunErr_q <= overrunErr_d;
    end
  end

  assign cmd.cmd_valid  = cmdValid_q;
  assign cmd.cmd_opcode = opcode_q;
  assign cmd.cmd_op_a   = opA_q;
  assign cmd.cmd_op_b   = opB_q;
  assign frame_err      = frameErr_q;
  assign overrun_err    = overrunErr_q;

endmodule

// File: tb/tb_fpu_uart_cmd_rx.sv
// Self-checking bench for fpu_uart_cmd_rx: table of packets plus hand-written
// sequences for overrun, framing error, glitch/timeout and mid-packet reset.
module tb_fpu_uart_cmd_rx;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        rxLine = 1'b1;
  logic [15:0] clksPerBit = 16'd16;
  logic        frameErr;
  logic        overrunErr;

  fpu_uart_cmd_rx_if cmdIf();

  fpu_uart_cmd_rx dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .r_Rx_Serial  (rxLine),
    .CLKS_PER_BIT (clksPerBit),
    .cmd          (cmdIf),
    .frame_err    (frameErr),
    .overrun_err  (overrunErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] pkt;
    logic [15:0] cpb;
    int          lineCpb;
    logic [7:0]  expOp;
    logic [15:0] expA;
    logic [15:0] expB;
  } vec_t;

  vec_t        vecs[5];
  logic [39:0] expQ[$];
  int          total = 0;
  int          bad = 0;
  int          frameCount = 0;
  int          overrunCount = 0;

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic sendByte(input logic [7:0] b, input int lineCpb, input logic stopBit);
    rxLine = 1'b0;
    tick(lineCpb);
    for (int i = 0; i < 8; i++) begin
      rxLine = b[i];
      tick(lineCpb);
    end
    rxLine = stopBit;
    tick(lineCpb);
    rxLine = 1'b1;
    tick(2 * lineCpb);
  endtask

  task automatic sendPacket(input logic [39:0] pkt, input int lineCpb);
    for (int k = 0; k < 5; k++) begin
      sendByte(pkt[39 - 8 * k -: 8], lineCpb, 1'b1);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    clksPerBit = v.cpb;
    expQ.push_back({v.expOp, v.expA, v.expB});
    sendPacket(v.pkt, v.lineCpb);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(name, 40'(expQ.size()), 40'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"},   40'(cmdIf.cmd_valid),  40'd0);
    checkOutput({tag, "_opcode"},  40'(cmdIf.cmd_opcode), 40'd0);
    checkOutput({tag, "_opA"},     40'(cmdIf.cmd_op_a),   40'd0);
    checkOutput({tag, "_opB"},     40'(cmdIf.cmd_op_b),   40'd0);
    checkOutput({tag, "_frame"},   40'(frameErr),         40'd0);
    checkOutput({tag, "_overrun"}, 40'(overrunErr),       40'd0);
  endtask

  // Scoreboard side: every accepted command must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_l) begin
      if (frameErr) frameCount++;
      if (overrunErr) overrunCount++;
      if (cmdIf.cmd_valid && cmdIf.cmd_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedCmd: got 0x%0h, want no command",
                   {cmdIf.cmd_opcode, cmdIf.cmd_op_a, cmdIf.cmd_op_b});
        end else begin
          checkOutput("cmdWord", {cmdIf.cmd_opcode, cmdIf.cmd_op_a, cmdIf.cmd_op_b},
                      expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int frameBefore;
    int overrunBefore;

    vecs[0] = '{40'h01_3C_00_40_00, 16'd16,  16,  8'h01, 16'h3C00, 16'h4000};
    vecs[1] = '{40'h7F_A5_5A_FF_00, 16'd16,  16,  8'h7F, 16'hA55A, 16'hFF00};
    vecs[2] = '{40'h01_3C_00_40_00, 16'd2,   4,   8'h01, 16'h3C00, 16'h4000};
    vecs[3] = '{40'h01_3C_00_40_00, 16'd348, 348, 8'h01, 16'h3C00, 16'h4000};
    vecs[4] = '{40'h80_00_01_80_00, 16'd5,   5,   8'h80, 16'h0001, 16'h8000};

    cmdIf.cmd_ready = 1'b1;
    tick(3);
    checkResetOutputs("reset");
    rst_l = 1'b1;
    tick(4);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      waitDrain($sformatf("vec%0d_drain", i), 2000);
    end
    checkOutput("table_frameErrs",   40'(frameCount),   40'd0);
    checkOutput("table_overrunErrs", 40'(overrunCount), 40'd0);

    // Overrun: held command survives a second packet, then handshake drops valid.
    clksPerBit = 16'd16;
    cmdIf.cmd_ready = 1'b0;
    overrunBefore = overrunCount;
    expQ.push_back({8'h01, 16'h3C00, 16'h4000});
    sendPacket(40'h01_3C_00_40_00, 16);
    sendPacket(40'h02_00_01_00_02, 16);
    checkOutput("ovr_pulses", 40'(overrunCount - overrunBefore), 40'd1);
    checkOutput("ovr_held",   40'(cmdIf.cmd_valid), 40'd1);
    checkOutput("ovr_word",   {cmdIf.cmd_opcode, cmdIf.cmd_op_a, cmdIf.cmd_op_b},
                {8'h01, 16'h3C00, 16'h4000});
    cmdIf.cmd_ready = 1'b1;
    tick(1);
    checkOutput("ovr_validDrop", 40'(cmdIf.cmd_valid), 40'd0);
    waitDrain("ovr_drain", 10);

    // Framing error on byte 2 discards the partial packet.
    frameBefore = frameCount;
    sendByte(8'h01, 16, 1'b1);
    sendByte(8'h3C, 16, 1'b1);
    sendByte(8'h00, 16, 1'b0);
    expQ.push_back({8'h03, 16'hC000, 16'h3C00});
    sendPacket(40'h03_C0_00_3C_00, 16);
    waitDrain("frm_drain", 500);
    checkOutput("frm_pulses", 40'(frameCount - frameBefore), 40'd1);

    // Short glitch, then a stale partial packet that must time out.
    frameBefore = frameCount;
    rxLine = 1'b0;
    tick(4);
    rxLine = 1'b1;
    tick(64);
    sendByte(8'hAA, 16, 1'b1);
    sendByte(8'h55, 16, 1'b1);
    tick(40 * 16);
    expQ.push_back({8'h04, 16'h1234, 16'h5678});
    sendPacket(40'h04_12_34_56_78, 16);
    waitDrain("tmo_drain", 500);
    tick(200);
    checkOutput("tmo_frameErrs", 40'(frameCount - frameBefore), 40'd0);

    // Reset during byte 3 data bits while a command is held.
    cmdIf.cmd_ready = 1'b0;
    sendPacket(40'h11_22_33_44_55, 16);
    checkOutput("rst_heldOpcode", 40'(cmdIf.cmd_opcode), 40'h11);
    sendByte(8'h21, 16, 1'b1);
    sendByte(8'h22, 16, 1'b1);
    sendByte(8'h23, 16, 1'b1);
    rxLine = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rxLine = i[0];
      tick(16);
    end
    rst_l = 1'b0;
    tick(2);
    rxLine = 1'b1;
    checkResetOutputs("midRst");
    rst_l = 1'b1;
    tick(40);
    cmdIf.cmd_ready = 1'b1;
    expQ.push_back({8'h05, 16'h3C00, 16'hBC00});
    sendPacket(40'h05_3C_00_BC_00, 16);
    waitDrain("rst_drain", 500);

    tick(50);
    checkOutput("final_queueEmpty", 40'(expQ.size()), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
